transpose_stream_ctrl: RTL and testbench

Streaming matrix-transpose controller for the ICA/whitening datapath. It accepts a SIZE_A x SIZE_B matrix as a row-major element stream, holds it in an internal register buffer, then emits the transpose (SIZE_B x SIZE_A) as a row-major stream. Both sides use valid/ready handshakes, so the block can sit between the covariance/whitening stages and the matrix-multiply units without frame-level buffering elsewhere.

---
 rtl/transpose_stream_ctrl.sv | 98 +++++++++
 tb/tb_transpose_stream_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/transpose_stream_ctrl.sv
// Streaming matrix transpose: loads a SIZE_A x SIZE_B row-major frame into a
// register buffer, then drains it column-by-column as a SIZE_B x SIZE_A stream.
module transpose_stream_ctrl #(
  parameter int SIZE_A = 8,
  parameter int SIZE_B = 8,
  parameter int N_BITS = 22
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_BITS-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [N_BITS-1:0] out_data,
  output logic              out_valid,
  output logic              out_last,
  input  logic              out_ready,
  output logic              frame_done,
  output logic              err
);

  localparam int RW    = (SIZE_A > 1) ? $clog2(SIZE_A) : 1;
  localparam int CW    = (SIZE_B > 1) ? $clog2(SIZE_B) : 1;
  localparam int DEPTH = SIZE_A * SIZE_B;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [RW-1:0] LAST_R = RW'(SIZE_A - 1);
  localparam logic [CW-1:0] LAST_C = CW'(SIZE_B - 1);

  typedef enum logic {LOAD, DRAIN} state_t;
  state_t state, state_nxt;

  // rd_c walks input rows, rd_r walks input columns
  logic [RW-1:0]     wr_r, rd_c;
  logic [CW-1:0]     wr_c, rd_r;
  logic [N_BITS-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_idx, rd_idx;
  logic              wr_fire, rd_fire, wr_final, rd_final;

  assign in_ready  = (state == LOAD);
  assign out_valid = (state == DRAIN);
  assign wr_fire   = in_valid && in_ready;
  assign rd_fire   = out_valid && out_ready;
  assign wr_final  = (wr_r == LAST_R) && (wr_c == LAST_C);
  assign rd_final  = (rd_r == LAST_C) && (rd_c == LAST_R);
  assign wr_idx    = AW'(wr_r) * AW'(SIZE_B) + AW'(wr_c);
  assign rd_idx    = AW'(rd_c) * AW'(SIZE_B) + AW'(rd_r);
  assign out_last  = out_valid && rd_final;
  assign out_data  = out_valid ? mem[rd_idx] : '0;

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:  if (wr_fire && wr_final) state_nxt = DRAIN;
      DRAIN: if (rd_fire && rd_final) state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_r       <= '0;
      wr_c       <= '0;
      rd_r       <= '0;
      rd_c       <= '0;
      frame_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      frame_done <= rd_fire && rd_final;
      if (wr_fire) begin
        if (in_last != wr_final) err <= 1'b1;
        if (wr_c == LAST_C) begin
          wr_c <= '0;
          wr_r <= (wr_r == LAST_R) ? '0 : wr_r + RW'(1);
        end else begin
          wr_c <= wr_c + CW'(1);
        end
      end
      if (rd_fire) begin
        if (rd_c == LAST_R) begin
          rd_c <= '0;
          rd_r <= (rd_r == LAST_C) ? '0 : rd_r + CW'(1);
        end else begin
          rd_c <= rd_c + RW'(1);
        end
      end
    end
  end

  // Frame buffer holds no reset: contents are only read after a full load.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_idx] <= in_data;
  end

endmodule

// File: tb/tb_transpose_stream_ctrl.sv
// Directed/randomized bench for transpose_stream_ctrl: a 2x3 and an 8x8 instance
// checked against a queue-based transpose model.
module tb_transpose_stream_ctrl;
  localparam int NB = 22;
  typedef logic [NB-1:0] elem_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  elem_t a_in_data, a_out_data, b_in_data, b_out_data;
  logic  a_in_valid, a_in_last, a_in_ready, a_out_valid, a_out_last, a_out_ready, a_frame_done, a_err;
  logic  b_in_valid, b_in_last, b_in_ready, b_out_valid, b_out_last, b_out_ready, b_frame_done, b_err;

  int vectors = 0;
  int miscompares = 0;
  bit err_model = 1'b0;
  elem_t q[$];
  elem_t e[$];

  transpose_stream_ctrl #(.SIZE_A(2), .SIZE_B(3), .N_BITS(NB)) u_a (
    .clk(clk), .rst_n(rst_n), .in_data(a_in_data), .in_valid(a_in_valid), .in_last(a_in_last),
    .in_ready(a_in_ready), .out_data(a_out_data), .out_valid(a_out_valid), .out_last(a_out_last),
    .out_ready(a_out_ready), .frame_done(a_frame_done), .err(a_err));

  transpose_stream_ctrl #(.SIZE_A(8), .SIZE_B(8), .N_BITS(NB)) u_b (
    .clk(clk), .rst_n(rst_n), .in_data(b_in_data), .in_valid(b_in_valid), .in_last(b_in_last),
    .in_ready(b_in_ready), .out_data(b_out_data), .out_valid(b_out_valid), .out_last(b_out_last),
    .out_ready(b_out_ready), .frame_done(b_frame_done), .err(b_err));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // out[i][j] = in[j][i], emitted row-major
  function automatic void transpose_model(input elem_t src[$], input int rows, input int cols,
                                          output elem_t dst[$]);
    dst = {};
    for (int i = 0; i < cols; i++)
      for (int j = 0; j < rows; j++)
        dst.push_back(src[j*cols + i]);
  endfunction

  task automatic send_a(input elem_t d[$], input int last_pos, input bit gaps);
    int k = 0;
    int budget = 0;
    while (k < d.size()) begin
      @(negedge clk);
      check("a_load_in_ready", 32'(a_in_ready), 32'd1);
      check("a_load_out_valid", 32'(a_out_valid), 32'd0);
      check("a_load_out_data", 32'(a_out_data), 32'd0);
      check("a_err", 32'(a_err), 32'(err_model));
      a_in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      a_in_data  = d[k];
      a_in_last  = (k == last_pos);
      @(posedge clk);
      if (a_in_valid) begin
        if (a_in_last != (k == d.size() - 1)) err_model = 1'b1;
        k++;
      end
      budget++;
      if (budget > 300) begin
        check("a_send_timeout", 32'(k), 32'(d.size()));
        break;
      end
    end
  endtask

  task automatic recv_a(input elem_t x[$], input bit stalls, input bit hold_in, input int stop_after);
    int idx = 0;
    int budget = 0;
    while (idx < x.size() && idx != stop_after) begin
      @(negedge clk);
      check("a_drain_out_valid", 32'(a_out_valid), 32'd1);
      check("a_drain_in_ready", 32'(a_in_ready), 32'd0);
      check("a_out_data", 32'(a_out_data), 32'(x[idx]));
      check("a_out_last", 32'(a_out_last), 32'(idx == x.size() - 1));
      check("a_drain_frame_done", 32'(a_frame_done), 32'd0);
      check("a_err", 32'(a_err), 32'(err_model));
      a_in_valid  = hold_in;
      a_in_data   = elem_t'($urandom);
      a_in_last   = hold_in ? 1'($urandom_range(0, 1)) : 1'b0;
      a_out_ready = stalls ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk);
      if (a_out_ready) idx++;
      budget++;
      if (budget > 300) begin
        check("a_recv_timeout", 32'(idx), 32'(x.size()));
        return;
      end
    end
    if (idx != x.size()) return;
    @(negedge clk);
    a_in_valid = 1'b0;
    a_in_last  = 1'b0;
    a_out_ready = 1'b0;
    check("a_frame_done_pulse", 32'(a_frame_done), 32'd1);
    check("a_post_in_ready", 32'(a_in_ready), 32'd1);
    check("a_post_out_valid", 32'(a_out_valid), 32'd0);
    check("a_post_out_last", 32'(a_out_last), 32'd0);
    @(negedge clk);
    check("a_frame_done_low", 32'(a_frame_done), 32'd0);
  endtask

  task automatic send_b(input elem_t d[$]);
    int k = 0;
    int budget = 0;
    while (k < d.size()) begin
      @(negedge clk);
      check("b_load_in_ready", 32'(b_in_ready), 32'd1);
      check("b_load_out_valid", 32'(b_out_valid), 32'd0);
      b_in_valid = 1'($urandom_range(0, 1));
      b_in_data  = d[k];
      b_in_last  = (k == d.size() - 1);
      @(posedge clk);
      if (b_in_valid) k++;
      budget++;
      if (budget > 2000) begin
        check("b_send_timeout", 32'(k), 32'(d.size()));
        break;
      end
    end
  endtask

  task automatic recv_b();
    int idx = 0;
    int budget = 0;
    while (idx < 64) begin
      @(negedge clk);
      b_in_valid = 1'b0;
      check("b_drain_out_valid", 32'(b_out_valid), 32'd1);
      check("b_drain_in_ready", 32'(b_in_ready), 32'd0);
      check("b_out_data", 32'(b_out_data), 32'((idx % 8) * 8 + idx / 8));
      check("b_out_last", 32'(b_out_last), 32'(idx == 63));
      b_out_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      if (b_out_ready) idx++;
      budget++;
      if (budget > 2000) begin
        check("b_recv_timeout", 32'(idx), 32'd64);
        return;
      end
    end
    @(negedge clk);
    b_out_ready = 1'b0;
    check("b_frame_done_pulse", 32'(b_frame_done), 32'd1);
    check("b_post_in_ready", 32'(b_in_ready), 32'd1);
    check("b_err", 32'(b_err), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    {a_in_valid, a_in_last, a_out_ready, b_in_valid, b_in_last, b_out_ready} = '0;
    a_in_data = '0;
    b_in_data = '0;
    #1;
    check("rst_in_ready", 32'(a_in_ready), 32'd1);
    check("rst_out_valid", 32'(a_out_valid), 32'd0);
    check("rst_out_last", 32'(a_out_last), 32'd0);
    check("rst_out_data", 32'(a_out_data), 32'd0);
    check("rst_frame_done", 32'(a_frame_done), 32'd0);
    check("rst_err", 32'(a_err), 32'd0);
    check("rst_b_in_ready", 32'(b_in_ready), 32'd1);
    check("rst_b_out_valid", 32'(b_out_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Basic 2x3 frame with fixed expected order
    q.delete();
    for (int k = 1; k <= 6; k++) q.push_back(elem_t'(k));
    e.delete();
    e.push_back(22'd1); e.push_back(22'd4); e.push_back(22'd2);
    e.push_back(22'd5); e.push_back(22'd3); e.push_back(22'd6);
    send_a(q, 5, 1'b0);
    recv_a(e, 1'b0, 1'b0, -1);

    // Width extremes
    q.delete();
    q.push_back(22'h3FFFFF); q.push_back(22'h200000); q.push_back(22'h000000);
    q.push_back(22'h000001); q.push_back(22'h1FFFFF); q.push_back(22'h3FFFFE);
    transpose_model(q, 2, 3, e);
    send_a(q, 5, 1'b1);
    recv_a(e, 1'b1, 1'b0, -1);

    // 8x8 with random gaps and stalls
    q.delete();
    for (int k = 0; k < 64; k++) q.push_back(elem_t'(k));
    send_b(q);
    recv_b();

    // Misplaced in_last: frame still 6 elements, err sticky through a clean frame
    q.delete();
    for (int k = 0; k < 6; k++) q.push_back(elem_t'($urandom));
    transpose_model(q, 2, 3, e);
    send_a(q, 2, 1'b0);
    recv_a(e, 1'b1, 1'b0, -1);
    check("err_set", 32'(a_err), 32'd1);
    q.delete();
    for (int k = 0; k < 6; k++) q.push_back(elem_t'($urandom));
    transpose_model(q, 2, 3, e);
    send_a(q, 5, 1'b1);
    recv_a(e, 1'b0, 1'b0, -1);
    check("err_sticky", 32'(a_err), 32'd1);

    // Async reset after two outputs of a frame
    q.delete();
    for (int k = 0; k < 6; k++) q.push_back(elem_t'($urandom));
    transpose_model(q, 2, 3, e);
    send_a(q, 5, 1'b0);
    recv_a(e, 1'b0, 1'b0, 2);
    #2;
    rst_n = 1'b0;
    err_model = 1'b0;
    #1;
    check("midrst_out_valid", 32'(a_out_valid), 32'd0);
    check("midrst_in_ready", 32'(a_in_ready), 32'd1);
    check("midrst_err", 32'(a_err), 32'd0);
    check("midrst_out_last", 32'(a_out_last), 32'd0);
    @(negedge clk);
    a_out_ready = 1'b0;
    rst_n = 1'b1;
    q.delete();
    for (int k = 7; k <= 12; k++) q.push_back(elem_t'(k));
    transpose_model(q, 2, 3, e);
    send_a(q, 5, 1'b0);
    recv_a(e, 1'b1, 1'b0, -1);

    // Back-to-back frames with in_valid held high during drain
    q.delete();
    for (int k = 0; k < 6; k++) q.push_back(elem_t'($urandom));
    transpose_model(q, 2, 3, e);
    send_a(q, 5, 1'b0);
    recv_a(e, 1'b1, 1'b1, -1);
    q.delete();
    for (int k = 0; k < 6; k++) q.push_back(elem_t'($urandom));
    transpose_model(q, 2, 3, e);
    send_a(q, 5, 1'b0);
    recv_a(e, 1'b0, 1'b1, -1);
    check("final_err", 32'(a_err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
